// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared encodings and entry layout for the pipeline trace buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    localparam logic [1:0] W_PC    = 2'd0;
    localparam logic [1:0] W_INSTR = 2'd1;
    localparam logic [1:0] W_ALU   = 2'd2;
    localparam logic [1:0] W_FLAGS = 2'd3;

    // Entry layout: {Stall, JumpFlag[1:0], ALUResult_ex, Instruction_id, PC}
    localparam int ENTRY_W   = 99;
    localparam int OFF_PC    = 0;
    localparam int OFF_INSTR = 32;
    localparam int OFF_ALU   = 64;
    localparam int OFF_JUMP  = 96;
    localparam int OFF_STALL = 98;

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
//  Module      : trace_ram
//  Description : DEPTH x WIDTH storage, one synchronous write, async read.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int WIDTH = 99
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_trace_buffer
//  Description : Circular capture of core debug outputs around a PC trigger,
//                streamed oldest-first as 4 words per entry.
//                Optional macro TRACE_SKIP_STALL_EN: stalled cycles not recorded.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   PC,
    input  logic [31:0]   Instruction_id,
    input  logic [31:0]   ALUResult_ex,
    input  logic [1:0]    JumpFlag,
    input  logic          Stall,
    input  logic          arm,
    input  logic [31:0]   trig_pc,
    input  logic [AW-1:0] post_cnt,
    output logic [1:0]    state,
    output logic          triggered,
    output logic [AW:0]   entry_cnt,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [31:0]   rd_data,
    output logic [1:0]    rd_word,
    output logic          rd_last
);

    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_post_cnt;
    logic [AW-1:0]      r_post_ctr;
    logic [AW:0]        r_entry_cnt;
    logic [AW:0]        r_rd_idx;
    logic [31:0]        r_trig_pc;
    logic               r_triggered;
    logic               r_rd_valid;
    logic [1:0]         r_rd_word;

    logic               w_skip;
    logic               w_rec;
    logic               w_hit;
    logic               w_post_done;
    logic               w_enter_read;
    logic               w_xfer;
    logic               w_last;
    logic [AW-1:0]      w_wr_ptr_nxt;
    logic [AW:0]        w_cnt_nxt;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_rd_entry;

`ifdef TRACE_SKIP_STALL_EN
    assign w_skip = Stall;
`else
    assign w_skip = 1'b0;
`endif

    assign w_rec        = ((r_state == ST_ARMED) || (r_state == ST_POST)) && !w_skip;
    assign w_hit        = w_rec && (r_state == ST_ARMED) && (PC == r_trig_pc);
    assign w_post_done  = w_rec && (r_state == ST_POST) && (r_post_ctr == AW'(1));
    assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
    assign w_cnt_nxt    = (r_entry_cnt == c_full) ? r_entry_cnt : r_entry_cnt + 1'b1;
    assign w_entry      = {Stall, JumpFlag, ALUResult_ex, Instruction_id, PC};
    assign w_xfer       = r_rd_valid && rd_ready;
    assign w_last       = r_rd_valid && (r_rd_word == W_FLAGS) &&
                          (r_rd_idx == r_entry_cnt - 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (arm) w_state_nxt = ST_ARMED;
            ST_ARMED: if (w_hit) w_state_nxt = (r_post_cnt == '0) ? ST_READ : ST_POST;
            ST_POST:  if (w_post_done) w_state_nxt = ST_READ;
            ST_READ:  if (w_xfer && w_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_read = (w_state_nxt == ST_READ) && (r_state != ST_READ);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_post_cnt  <= '0;
            r_post_ctr  <= '0;
            r_entry_cnt <= '0;
            r_rd_idx    <= '0;
            r_trig_pc   <= '0;
            r_triggered <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_word   <= W_PC;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && arm) begin
                r_trig_pc   <= trig_pc;
                r_post_cnt  <= post_cnt;
                r_wr_ptr    <= '0;
                r_entry_cnt <= '0;
                r_triggered <= 1'b0;
            end
            if (w_rec) begin
                r_wr_ptr    <= w_wr_ptr_nxt;
                r_entry_cnt <= w_cnt_nxt;
            end
            if (w_hit) begin
                r_triggered <= 1'b1;
                r_post_ctr  <= r_post_cnt;
            end else if (w_rec && (r_state == ST_POST)) begin
                r_post_ctr <= r_post_ctr - 1'b1;
            end
            // Oldest retained entry sits entry_cnt slots behind the final write pointer
            if (w_enter_read) begin
                r_rd_ptr   <= w_wr_ptr_nxt - w_cnt_nxt[AW-1:0];
                r_rd_idx   <= '0;
                r_rd_word  <= W_PC;
                r_rd_valid <= 1'b1;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_rd_valid <= 1'b0;
                    r_rd_word  <= W_PC;
                end else begin
                    r_rd_word <= r_rd_word + 1'b1;
                    if (r_rd_word == W_FLAGS) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_rd_idx <= r_rd_idx + 1'b1;
                    end
                end
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_rec),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    always_comb begin
        rd_data = 32'd0;
        if (r_rd_valid) begin
            case (r_rd_word)
                W_PC:    rd_data = w_rd_entry[OFF_PC +: 32];
                W_INSTR: rd_data = w_rd_entry[OFF_INSTR +: 32];
                W_ALU:   rd_data = w_rd_entry[OFF_ALU +: 32];
                default: rd_data = {29'd0, w_rd_entry[OFF_STALL], w_rd_entry[OFF_JUMP +: 2]};
            endcase
        end
    end

    assign state     = r_state;
    assign triggered = r_triggered;
    assign entry_cnt = r_entry_cnt;
    assign rd_valid  = r_rd_valid;
    assign rd_word   = r_rd_word;
    assign rd_last   = w_last;

endmodule
`default_nettype wire

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
Downstream observer of the 5-stage RISC-V core; consumes the core's debug outputs (PC, Instruction_id, ALUResult_ex, JumpFlag, Stall) every clock. Records them into a circular buffer once armed, stops after a PC-match trigger plus a programmable post-trigger count, then streams the captured window oldest-first over a valid/ready word interface for a UART/display dumper.

Parameters:
DEPTH, 64, number of trace entries; power of 2, minimum 4
AW, 6, log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
PC  in  32  core IF-stage PC
Instruction_id  in  32  core ID-stage instruction
ALUResult_ex  in  32  core EX-stage ALU result
JumpFlag  in  2  {Jump, Branch} from core
Stall  in  1  core load-use stall
arm  in  1  start capture; honoured only in IDLE
trig_pc  in  32  trigger PC; latched on accepted arm
post_cnt  in  AW  entries recorded after the trigger entry; latched on accepted arm
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 READ
triggered  out  1  trigger seen since last arm
entry_cnt  out  AW+1  valid entries, saturates at DEPTH
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts word
rd_data  out  32  trace word
rd_word  out  2  word index within entry
rd_last  out  1  final word of final entry

Behaviour:
- Reset: state IDLE, wr_ptr 0, rd_ptr 0, entry_cnt 0, triggered 0, rd_valid 0, rd_word 0, rd_last 0, rd_data 0. RAM contents not cleared. Reset overrides every other input, including mid-capture and mid-readout.
- Entry = {Stall, JumpFlag, ALUResult_ex, Instruction_id, PC} = 99 bits, sampled in the same cycle it is written.
- IDLE: arm=1 latches trig_pc/post_cnt and clears wr_ptr, entry_cnt, and triggered. Next state is ARMED. No write occurs in the arm cycle.
- ARMED: every recorded cycle writes an entry at wr_ptr; wr_ptr increments mod DEPTH; entry_cnt increments, saturating at DEPTH (oldest entries overwritten).
  - If PC==latched trig_pc in a recorded cycle, that entry is written and triggered is set.
  - On trigger, the post counter loads post_cnt. Next state is READ if post_cnt==0, else POST.
- POST: record each cycle and decrement the post counter. The cycle that writes the last post entry (counter 1->0) transitions to READ. PC matches are ignored. Since post_cnt<=DEPTH-1, the trigger entry is always retained.
- Entering READ:
  - rd_ptr = (wr_ptr_next - entry_cnt_next) mod DEPTH, rd_word=0, rd_valid=1 from the first READ cycle.
  - No further writes occur.
- READ: rd_data is a combinational mux of RAM[rd_ptr] by rd_word:
  - word 0: PC
  - word 1: Instruction_id
  - word 2: ALUResult_ex
  - word 3: {29'b0, Stall, JumpFlag}
- A word transfers when rd_valid&rd_ready. rd_word increments; after word 3, rd_word returns to 0 and rd_ptr increments mod DEPTH.
- While rd_valid&!rd_ready, rd_data/rd_word/rd_last stay stable.
- rd_last=1 only on word 3 of entry entry_cnt-1. Its transfer returns the block to IDLE with rd_valid=0 next cycle; entry_cnt and triggered hold until next arm.
- arm outside IDLE is ignored. The input ports are not registered before the write.

Optional Feature:
TRACE_SKIP_STALL_EN
- Defined: cycles with Stall=1 are not recorded. They cannot trigger, do not advance wr_ptr/entry_cnt, and do not decrement the post counter.
- Undefined: every ARMED/POST cycle is recorded regardless of Stall.

Decomposition:
- Package trace_pkg holds the following constants:
  - state encodings (ST_IDLE..ST_READ)
  - word indices (W_PC, W_INSTR, W_ALU, W_FLAGS)
  - ENTRY_W=99 and field bit offsets
- One sub-module, trace_ram: DEPTH x ENTRY_W, one synchronous write port, asynchronous read port.

Test Plan:
1. Arm with trig_pc=0x10, post_cnt=2; PC=0x0,0x4,0x8,... one per cycle from the first ARMED cycle, no stalls -> entry_cnt=7; 28 words read; word 0=0x0, last PC word=0x18; rd_last on word 27; then IDLE.
2. DEPTH=64, trigger at PC=T after 100 recorded cycles, post_cnt=5 -> entry_cnt=64; first PC read = T-232; trigger entry is entry index 58.
3. rd_ready pattern 1,0,0,1,0,1... during readout -> rd_data/rd_word held while not ready; exactly 4*entry_cnt transfers, none duplicated or dropped.
4. Stall=1 on 3 cycles before trigger, trig_pc=0x10, post_cnt=0 -> with TRACE_SKIP_STALL_EN: entry_cnt counts only Stall=0 cycles. Without it: entry_cnt is 3 higher and those entries' flags word has bit 2=1.
5. Assert reset during READ after 5 words -> next cycle state=0, rd_valid=0, entry_cnt=0. A following arm and test-1 stimulus reproduces test-1 output.
6. arm pulsed again during ARMED and POST, plus trig_pc changed after arm -> ignored; trigger still uses the originally latched value.
